// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: the stage takes the master modport, the surrounding pipeline/regfile the slave.
// Groups IF/ID inputs, register-file read port, downstream hold/flush and the ID/EX outputs.
interface id_ex_stage_if;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc_plus2;
    logic [3:0]  src_reg1;
    logic [3:0]  src_reg2;
    logic [15:0] src_data1;
    logic [15:0] src_data2;
    logic        ex_hold;
    logic        flush;
    logic        stall;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [3:0]  ex_dst_reg;
    logic [3:0]  ex_src_reg1;
    logic [3:0]  ex_src_reg2;
    logic [15:0] ex_op1;
    logic [15:0] ex_op2;
    logic [15:0] ex_imm;
    logic        ex_use_imm;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_halt;
    logic [15:0] ex_pc_plus2;

    modport master (
        input  id_valid, id_instr, id_pc_plus2, src_data1, src_data2, ex_hold, flush,
        output src_reg1, src_reg2, stall, ex_valid, ex_opcode, ex_dst_reg, ex_src_reg1,
               ex_src_reg2, ex_op1, ex_op2, ex_imm, ex_use_imm, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_halt, ex_pc_plus2
    );

    modport slave (
        output id_valid, id_instr, id_pc_plus2, src_data1, src_data2, ex_hold, flush,
        input  src_reg1, src_reg2, stall, ex_valid, ex_opcode, ex_dst_reg, ex_src_reg1,
               ex_src_reg2, ex_op1, ex_op2, ex_imm, ex_use_imm, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_halt, ex_pc_plus2
    );
endinterface

// File: rtl/id_ex_stage.sv
// WISC decode stage + ID/EX register: 1-cycle decode-to-EX; ex_hold freezes ID/EX and raises stall,
// flush during hold is deferred. LOAD_USE_STALL_EN enables load-use bubble insertion.
module id_ex_stage (
    input  logic            clk,
    input  logic            rst,
    id_ex_stage_if.master   bus
);
    typedef struct packed {
        logic        valid;
        logic [3:0]  opcode;
        logic [3:0]  dst;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] imm;
        logic        use_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        halt;
        logic [15:0] pc_plus2;
    } idex_t;

    idex_t idex_q, idex_d;
    logic  flush_pend_q, flush_pend_d;

    logic [3:0]  opc, rd, rs, rt;
    logic [3:0]  dec_src1, dec_src2, dec_dst;
    logic        uses_src1, uses_src2;
    logic [15:0] dec_imm;
    logic        dec_use_imm, dec_reg_write, dec_mem_read, dec_mem_write, dec_halt;
    logic        hazard;

    assign opc = bus.id_instr[15:12];
    assign rd  = bus.id_instr[11:8];
    assign rs  = bus.id_instr[7:4];
    assign rt  = bus.id_instr[3:0];

    always_comb begin
        dec_src1      = 4'd0;
        dec_src2      = 4'd0;
        dec_dst       = 4'd0;
        uses_src1     = 1'b0;
        uses_src2     = 1'b0;
        dec_imm       = 16'd0;
        dec_use_imm   = 1'b0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_halt      = 1'b0;
        case (opc)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
                dec_src1 = rs;  uses_src1 = 1'b1;
                dec_src2 = rt;  uses_src2 = 1'b1;
                dec_dst  = rd;  dec_reg_write = 1'b1;
            end
            4'h4, 4'h5, 4'h6: begin
                dec_src1 = rs;  uses_src1 = 1'b1;
                dec_imm  = {12'd0, rt};
                dec_use_imm = 1'b1;
                dec_dst  = rd;  dec_reg_write = 1'b1;
            end
            4'h8: begin
                dec_src1 = rs;  uses_src1 = 1'b1;
                dec_imm  = {{11{rt[3]}}, rt, 1'b0};
                dec_use_imm = 1'b1;
                dec_mem_read = 1'b1;
                dec_dst  = rd;  dec_reg_write = 1'b1;
            end
            4'h9: begin
                // store data comes from the rd field
                dec_src1 = rs;  uses_src1 = 1'b1;
                dec_src2 = rd;  uses_src2 = 1'b1;
                dec_imm  = {{11{rt[3]}}, rt, 1'b0};
                dec_use_imm = 1'b1;
                dec_mem_write = 1'b1;
            end
            4'hA, 4'hB: begin
                dec_src1 = rd;  uses_src1 = 1'b1;
                dec_imm  = {8'd0, bus.id_instr[7:0]};
                dec_use_imm = 1'b1;
                dec_dst  = rd;  dec_reg_write = 1'b1;
            end
            4'hD: begin
                dec_src1 = rs;  uses_src1 = 1'b1;
            end
            4'hE: begin
                dec_dst  = rd;  dec_reg_write = 1'b1;
            end
            4'hF: dec_halt = 1'b1;
            default: ;
        endcase
    end

    assign bus.src_reg1 = dec_src1;
    assign bus.src_reg2 = dec_src2;

`ifdef LOAD_USE_STALL_EN
    // SW store data is excluded: MEM-to-MEM forwarding covers it
    assign hazard = bus.id_valid && idex_q.valid && idex_q.mem_read && (idex_q.dst != 4'd0) &&
                    ((uses_src1 && (dec_src1 == idex_q.dst)) ||
                     (uses_src2 && (dec_src2 == idex_q.dst) && (opc != 4'h9)));
`else
    assign hazard = 1'b0;
`endif

    assign bus.stall = hazard | bus.ex_hold;

    always_comb begin
        idex_d       = idex_q;
        flush_pend_d = bus.ex_hold ? (flush_pend_q | bus.flush) : 1'b0;
        if (!bus.ex_hold) begin
            if (bus.flush || flush_pend_q || hazard) begin
                idex_d = '0;
            end else begin
                idex_d.valid     = bus.id_valid;
                idex_d.opcode    = opc;
                idex_d.dst       = dec_dst;
                idex_d.src1      = dec_src1;
                idex_d.src2      = dec_src2;
                idex_d.op1       = bus.src_data1;
                idex_d.op2       = bus.src_data2;
                idex_d.imm       = dec_imm;
                idex_d.use_imm   = dec_use_imm;
                idex_d.reg_write = dec_reg_write & bus.id_valid;
                idex_d.mem_read  = dec_mem_read  & bus.id_valid;
                idex_d.mem_write = dec_mem_write & bus.id_valid;
                idex_d.halt      = dec_halt      & bus.id_valid;
                idex_d.pc_plus2  = bus.id_pc_plus2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            idex_q       <= idex_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign bus.ex_valid     = idex_q.valid;
    assign bus.ex_opcode    = idex_q.opcode;
    assign bus.ex_dst_reg   = idex_q.dst;
    assign bus.ex_src_reg1  = idex_q.src1;
    assign bus.ex_src_reg2  = idex_q.src2;
    assign bus.ex_op1       = idex_q.op1;
    assign bus.ex_op2       = idex_q.op2;
    assign bus.ex_imm       = idex_q.imm;
    assign bus.ex_use_imm   = idex_q.use_imm;
    assign bus.ex_reg_write = idex_q.reg_write;
    assign bus.ex_mem_read  = idex_q.mem_read;
    assign bus.ex_mem_write = idex_q.mem_write;
    assign bus.ex_halt      = idex_q.halt;
    assign bus.ex_pc_plus2  = idex_q.pc_plus2;
endmodule
